attn_score_seq: RTL and testbench

- Autonomous sequencer for the attention-score unit (Q·K^T, transpose block plus GEMM tile system); replaces manual host control.
- On one command it runs four steps in order: start transpose of K, wait for transpose done, copy K^T from transpose port B into the GEMM X SRAM element by element, then start the GEMM and wait for its done.
- Sits between the host command interface and the score unit's tr_*/tr_b_*/cpu_x_*/gemm_* ports.

---
 rtl/attn_score_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_attn_score_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_score_seq.sv
// rtl/attn_score_seq.sv - sequencer for transpose, K^T copy into GEMM X SRAM, then GEMM
module attn_score_seq #(
    parameter int T          = 8,
    parameter int DMAX       = 1024,
    parameter int DATA_W     = 32,
    parameter int BYTE_W     = DATA_W / 8,
    parameter int RD_TIMEOUT = 64,
    parameter int T_W        = (T <= 1) ? 1 : $clog2(T),
    parameter int D_W        = (DMAX <= 1) ? 1 : $clog2(DMAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic [15:0]       D_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              tr_start,
    input  logic              tr_busy,
    input  logic              tr_done,
    output logic              tr_b_re,
    output logic [D_W-1:0]    tr_b_row,
    output logic [T_W-1:0]    tr_b_col,
    input  logic [DATA_W-1:0] tr_b_rdata,
    input  logic              tr_b_rvalid,
    output logic              cpu_x_we,
    output logic [D_W-1:0]    cpu_x_k,
    output logic [T_W-1:0]    cpu_x_n,
    output logic [DATA_W-1:0] cpu_x_wdata,
    output logic [BYTE_W-1:0] cpu_x_wmask,
    output logic              gemm_start,
    input  logic              gemm_busy,
    input  logic              gemm_done
);

    localparam int K_W  = D_W + 1;
    localparam int TO_W = $clog2(RD_TIMEOUT + 1);

    // err is registered, so deciding at count RD_TIMEOUT-2 puts the pulse
    // exactly RD_TIMEOUT cycles after the tr_b_re cycle.
    localparam logic [TO_W-1:0] TO_FIRE = TO_W'((RD_TIMEOUT >= 2) ? RD_TIMEOUT - 2 : 0);
    localparam logic [K_W-1:0]  DMAX_K  = K_W'(DMAX);
    localparam logic [T_W-1:0]  N_LAST  = T_W'(T - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TR_KICK,
        S_TR_WAIT,
        S_CP_RD,
        S_CP_WAIT,
        S_CP_WR,
        S_GEMM_KICK,
        S_GEMM_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [T_W-1:0]      n_q, n_d;
    logic [K_W-1:0]      d_eff_q, d_eff_d;
    logic [K_W-1:0]      d_eff_in;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                tr_start_q, tr_start_d;
    logic                tr_b_re_q, tr_b_re_d;
    logic                cpu_x_we_q, cpu_x_we_d;
    logic                gemm_start_q, gemm_start_d;
    logic                last_elem;

    // Clamp the requested head dimension to the SRAM depth.
    always_comb begin
        d_eff_in = K_W'(D_len);
        if (32'(D_len) > DMAX) begin
            d_eff_in = DMAX_K;
        end
    end

    assign last_elem = (k_q == d_eff_q - 1'b1) && (n_q == N_LAST);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        d_eff_d  = d_eff_q;
        to_cnt_d = to_cnt_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    if (d_eff_in == '0) begin
                        err_d = 1'b1;
                    end else begin
                        d_eff_d = d_eff_in;
                        k_d     = '0;
                        n_d     = '0;
                        state_d = S_TR_KICK;
                    end
                end
            end
            S_TR_KICK: begin
                if (tr_busy) begin
                    state_d = S_TR_WAIT;
                end
            end
            S_TR_WAIT: begin
                if (tr_done && !tr_busy) begin
                    k_d     = '0;
                    n_d     = '0;
                    state_d = S_CP_RD;
                end
            end
            S_CP_RD: begin
                to_cnt_d = '0;
                state_d  = S_CP_WAIT;
            end
            S_CP_WAIT: begin
                if (tr_b_rvalid) begin
                    wdata_d = tr_b_rdata;
                    state_d = S_CP_WR;
                end else if (to_cnt_q == TO_FIRE) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_CP_WR: begin
                // n walks the tile columns fastest, k the head dimension.
                if (n_q == N_LAST) begin
                    n_d = '0;
                    k_d = k_q + 1'b1;
                end else begin
                    n_d = n_q + 1'b1;
                end
                state_d = last_elem ? S_GEMM_KICK : S_CP_RD;
            end
            S_GEMM_KICK: begin
                if (gemm_busy) begin
                    state_d = S_GEMM_WAIT;
                end
            end
            S_GEMM_WAIT: begin
                if (gemm_done && !gemm_busy) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition; downstream engines keep running.
        if (state_q != S_IDLE && cmd_abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end

        // Strobes follow the state being entered so they are registered.
        busy_d       = (state_d != S_IDLE);
        tr_start_d   = (state_d == S_TR_KICK);
        tr_b_re_d    = (state_d == S_CP_RD);
        cpu_x_we_d   = (state_d == S_CP_WR);
        gemm_start_d = (state_d == S_GEMM_KICK);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            n_q          <= '0;
            d_eff_q      <= '0;
            to_cnt_q     <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tr_start_q   <= 1'b0;
            tr_b_re_q    <= 1'b0;
            cpu_x_we_q   <= 1'b0;
            gemm_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            d_eff_q      <= d_eff_d;
            to_cnt_q     <= to_cnt_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            tr_start_q   <= tr_start_d;
            tr_b_re_q    <= tr_b_re_d;
            cpu_x_we_q   <= cpu_x_we_d;
            gemm_start_q <= gemm_start_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign tr_start    = tr_start_q;
    assign tr_b_re     = tr_b_re_q;
    assign tr_b_row    = k_q[D_W-1:0];
    assign tr_b_col    = n_q;
    assign cpu_x_we    = cpu_x_we_q;
    assign cpu_x_k     = k_q[D_W-1:0];
    assign cpu_x_n     = n_q;
    assign cpu_x_wdata = wdata_q;
    assign cpu_x_wmask = '1;
    assign gemm_start  = gemm_start_q;

endmodule

// File: tb/tb_attn_score_seq.sv
// tb/tb_attn_score_seq.sv - randomized bench for attn_score_seq against a behavioural model
module tb_attn_score_seq;

    localparam int T          = 4;
    localparam int DMAX       = 16;
    localparam int DATA_W     = 32;
    localparam int BYTE_W     = 4;
    localparam int RD_TIMEOUT = 12;
    localparam int T_W        = 2;
    localparam int D_W        = 4;

    logic              clk;
    logic              rst;
    logic              cmd_start;
    logic              cmd_abort;
    logic [15:0]       D_len;
    logic              busy, done, err;
    logic              tr_start, tr_busy, tr_done;
    logic              tr_b_re;
    logic [D_W-1:0]    tr_b_row;
    logic [T_W-1:0]    tr_b_col;
    logic [DATA_W-1:0] tr_b_rdata;
    logic              tr_b_rvalid;
    logic              cpu_x_we;
    logic [D_W-1:0]    cpu_x_k;
    logic [T_W-1:0]    cpu_x_n;
    logic [DATA_W-1:0] cpu_x_wdata;
    logic [BYTE_W-1:0] cpu_x_wmask;
    logic              gemm_start, gemm_busy, gemm_done;

    attn_score_seq #(
        .T(T), .DMAX(DMAX), .DATA_W(DATA_W), .BYTE_W(BYTE_W),
        .RD_TIMEOUT(RD_TIMEOUT), .T_W(T_W), .D_W(D_W)
    ) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort), .D_len(D_len),
        .busy(busy), .done(done), .err(err),
        .tr_start(tr_start), .tr_busy(tr_busy), .tr_done(tr_done),
        .tr_b_re(tr_b_re), .tr_b_row(tr_b_row), .tr_b_col(tr_b_col),
        .tr_b_rdata(tr_b_rdata), .tr_b_rvalid(tr_b_rvalid),
        .cpu_x_we(cpu_x_we), .cpu_x_k(cpu_x_k), .cpu_x_n(cpu_x_n),
        .cpu_x_wdata(cpu_x_wdata), .cpu_x_wmask(cpu_x_wmask),
        .gemm_start(gemm_start), .gemm_busy(gemm_busy), .gemm_done(gemm_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int exp_total, rd_idx, wr_idx;
    int tr_starts, gemm_starts, done_cnt, err_cnt;
    int last_err_cyc, last_re_cyc, last_wr_k, last_wr_n;
    int lat = 1;
    int gemm_lat = 3;
    int tr_cnt, gemm_cnt, rd_cnt;
    bit withhold = 0;
    bit tr_start_prev, gemm_start_prev;
    logic [DATA_W-1:0] last_rd_data, rd_pend;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Observer plus transpose / read-port / GEMM models, all on the falling edge.
    initial begin
        tr_busy = 0; tr_done = 0; gemm_busy = 0; gemm_done = 0;
        tr_b_rvalid = 0; tr_b_rdata = '0; rd_cnt = 0; tr_cnt = 0; gemm_cnt = 0;
        tr_start_prev = 0; gemm_start_prev = 0; last_rd_data = '0; rd_pend = '0;
        forever begin
            @(negedge clk);
            if (tr_b_re) begin
                last_re_cyc = cyc;
                check_val("rd_in_range", 64'(rd_idx < exp_total), 64'd1);
                check_val("rd_row", 64'(tr_b_row), 64'(rd_idx / T));
                check_val("rd_col", 64'(tr_b_col), 64'(rd_idx % T));
                rd_idx++;
            end
            if (cpu_x_we) begin
                check_val("wr_k", 64'(cpu_x_k), 64'(wr_idx / T));
                check_val("wr_n", 64'(cpu_x_n), 64'(wr_idx % T));
                check_val("wr_data", 64'(cpu_x_wdata), 64'(last_rd_data));
                check_val("wr_mask", 64'(cpu_x_wmask), 64'hF);
                last_wr_k = int'(cpu_x_k);
                last_wr_n = int'(cpu_x_n);
                wr_idx++;
            end
            if (done) begin
                done_cnt++;
                check_val("busy_low_with_done", 64'(busy), 64'd0);
            end
            if (err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
            if (tr_start && !tr_start_prev) tr_starts++;
            if (gemm_start && !gemm_start_prev) gemm_starts++;

            tr_b_rvalid = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    tr_b_rvalid  = 1;
                    tr_b_rdata   = rd_pend;
                    last_rd_data = rd_pend;
                end
            end
            if (tr_b_re && !withhold) begin
                rd_cnt  = lat;
                rd_pend = $urandom;
            end

            if (tr_start && !tr_start_prev) begin
                tr_busy = 1; tr_done = 0; tr_cnt = $urandom_range(2, 5);
            end else if (tr_busy) begin
                tr_cnt--;
                if (tr_cnt == 0) begin tr_busy = 0; tr_done = 1; end
            end
            if (gemm_start && !gemm_start_prev) begin
                gemm_busy = 1; gemm_done = 0; gemm_cnt = gemm_lat;
            end else if (gemm_busy) begin
                gemm_cnt--;
                if (gemm_cnt == 0) begin gemm_busy = 0; gemm_done = 1; end
            end
            tr_start_prev   = tr_start;
            gemm_start_prev = gemm_start;
        end
    end

    task automatic start_cmd(input int dlen);
        int deff;
        deff        = (dlen > DMAX) ? DMAX : dlen;
        exp_total   = deff * T;
        rd_idx      = 0;
        wr_idx      = 0;
        done_cnt    = 0;
        err_cnt     = 0;
        tr_starts   = 0;
        gemm_starts = 0;
        D_len       = 16'(dlen);
        cmd_start   = 1;
        @(negedge clk); #1;
        cmd_start   = 0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0 || err_cnt > 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_full(input int dlen, input int latency);
        bit ok;
        int deff;
        deff = (dlen > DMAX) ? DMAX : dlen;
        lat  = latency;
        start_cmd(dlen);
        wait_end(3000, ok);
        check_val("run_finished", 64'(ok), 64'd1);
        check_val("run_done_cnt", 64'(done_cnt), 64'd1);
        check_val("run_err_cnt", 64'(err_cnt), 64'd0);
        check_val("run_reads", 64'(rd_idx), 64'(deff * T));
        check_val("run_writes", 64'(wr_idx), 64'(deff * T));
        check_val("run_last_k", 64'(last_wr_k), 64'(deff - 1));
        check_val("run_last_n", 64'(last_wr_n), 64'(T - 1));
        check_val("run_tr_starts", 64'(tr_starts), 64'd1);
        check_val("run_gemm_starts", 64'(gemm_starts), 64'd1);
        check_val("run_busy_after", 64'(busy), 64'd0);
        @(negedge clk); #1;
        check_val("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_err"}, 64'(err), 64'd0);
        check_val({tag, "_tr_start"}, 64'(tr_start), 64'd0);
        check_val({tag, "_tr_b_re"}, 64'(tr_b_re), 64'd0);
        check_val({tag, "_we"}, 64'(cpu_x_we), 64'd0);
        check_val({tag, "_gemm_start"}, 64'(gemm_start), 64'd0);
        check_val({tag, "_wmask"}, 64'(cpu_x_wmask), 64'hF);
    endtask

    initial begin
        bit ok;
        rst = 1; cmd_start = 0; cmd_abort = 0; D_len = '0;
        exp_total = 0; rd_idx = 0; wr_idx = 0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        check_val("reset_row", 64'(tr_b_row), 64'd0);
        check_val("reset_wdata", 64'(cpu_x_wdata), 64'd0);
        rst = 0;
        @(negedge clk); #1;
        check_quiet("post_reset");

        // Directed: D_len=3, latency 1
        run_full(3, 1);
        // Clamp: D_len=40 -> 16
        run_full(40, 2);
        // Random lengths and latencies
        for (int i = 0; i < 4; i++) begin
            run_full($urandom_range(1, 20), $urandom_range(1, 4));
        end

        // D_len == 0
        start_cmd(0);
        check_val("zero_err", 64'(err), 64'd1);
        check_val("zero_busy", 64'(busy), 64'd0);
        @(negedge clk); #1;
        check_val("zero_err_pulse", 64'(err), 64'd0);
        check_val("zero_busy2", 64'(busy), 64'd0);
        check_val("zero_tr_starts", 64'(tr_starts), 64'd0);

        // Read timeout
        withhold = 1;
        start_cmd(2);
        wait_end(500, ok);
        check_val("to_finished", 64'(ok), 64'd1);
        check_val("to_err_cnt", 64'(err_cnt), 64'd1);
        check_val("to_latency", 64'(last_err_cyc - last_re_cyc), 64'(RD_TIMEOUT));
        check_val("to_busy", 64'(busy), 64'd0);
        check_val("to_gemm_starts", 64'(gemm_starts), 64'd0);
        check_val("to_done_cnt", 64'(done_cnt), 64'd0);
        check_val("to_reads", 64'(rd_idx), 64'd1);
        withhold = 0;

        // Abort while waiting for read data, then a clean run
        withhold = 1;
        start_cmd(3);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (rd_idx > 0) begin ok = 1; break; end
        end
        check_val("abort_saw_read", 64'(ok), 64'd1);
        @(negedge clk); #1;
        cmd_abort = 1;
        @(negedge clk); #1;
        cmd_abort = 0;
        check_quiet("abort");
        withhold = 0;
        run_full(5, 2);

        // cmd_start during GEMM_WAIT is ignored
        gemm_lat = 12;
        lat = 1;
        start_cmd(2);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (gemm_busy) begin ok = 1; break; end
        end
        check_val("gw_saw_gemm_busy", 64'(ok), 64'd1);
        @(negedge clk); #1;
        cmd_start = 1;
        @(negedge clk); #1;
        cmd_start = 0;
        wait_end(500, ok);
        check_val("gw_finished", 64'(ok), 64'd1);
        repeat (20) @(negedge clk);
        #1;
        check_val("gw_done_cnt", 64'(done_cnt), 64'd1);
        check_val("gw_tr_starts", 64'(tr_starts), 64'd1);
        check_val("gw_busy", 64'(busy), 64'd0);
        gemm_lat = 3;

        // Asynchronous reset mid-copy
        lat = 1;
        start_cmd(16);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (wr_idx >= 5) begin ok = 1; break; end
        end
        check_val("rst_mid_copy_reached", 64'(ok), 64'd1);
        @(negedge clk); #2;
        rst = 1;
        #1;
        check_quiet("async_rst");
        @(negedge clk); #1;
        rst = 0;
        run_full(2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
